// File: rtl/cache_refill_unit.sv
// Cache miss refill engine: issues one line read, collects four beats into a
// 128-bit line (merging a pending store into its target word), then presents
// the line for a single-cycle bank write and returns the requested load word.
module cache_refill_unit #(
    parameter int unsigned TAGLEN   = 20,
    parameter int unsigned INDEXLEN = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic [31:0]         miss_addr_i,
    input  logic                miss_op_i,
    input  logic [3:0]          miss_wstrb_i,
    input  logic [31:0]         miss_wdata_i,
    output logic                rd_req_o,
    output logic [2:0]          rd_type_o,
    output logic [31:0]         rd_addr_o,
    input  logic                rd_rdy_i,
    input  logic                ret_valid_i,
    input  logic                ret_last_i,
    input  logic [31:0]         ret_data_i,
    output logic                fill_en_o,
    output logic [INDEXLEN-1:0] fill_idx_o,
    output logic [TAGLEN-1:0]   fill_tag_o,
    output logic [127:0]        fill_line_o,
    output logic                fill_dirty_o,
    output logic [31:0]         load_word_o,
    output logic                load_valid_o,
    output logic                busy_o,
    output logic                proto_err_o
);

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned BEATS    = 4;
    localparam int unsigned CNT_W    = 2;
    localparam int unsigned STRB_W   = 4;
    localparam int unsigned OFF_LSB  = 2;
    localparam int unsigned IDX_LSB  = 4;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        REQ  = 4'b0010,
        RECV = 4'b0100,
        FILL = 4'b1000
    } state_e;

    state_e                         state_q, state_d;
    logic [ADDR_W-1:OFF_LSB]        addr_q;
    logic                           op_q;
    logic [STRB_W-1:0]              wstrb_q;
    logic [WORD_W-1:0]              wdata_q;
    logic [CNT_W-1:0]               cnt_q;
    logic                           ovf_q;
    logic [BEATS-1:0][WORD_W-1:0]   line_q;
    logic [WORD_W-1:0]              load_word_q;
    logic                           rd_req_q;
    logic                           fill_en_q;
    logic                           load_valid_q;
    logic                           busy_q;
    logic                           proto_err_q;

    logic [CNT_W-1:0]               off_c;
    logic [WORD_W-1:0]              beat_word_c;
    logic                           beat_c;
    logic                           unused_addr_lo;

    // Byte offset bits never matter: the refill works on whole words.
    assign unused_addr_lo = ^miss_addr_i[OFF_LSB-1:0];

    assign off_c  = addr_q[OFF_LSB +: CNT_W];
    assign beat_c = (state_q == RECV) && ret_valid_i;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i)                   state_d = REQ;
            REQ:     if (rd_rdy_i)                  state_d = RECV;
            RECV:    if (ret_valid_i && ret_last_i) state_d = FILL;
            FILL:                                   state_d = IDLE;
            default:                                state_d = IDLE;
        endcase
    end

    // Incoming beat with the pending store's bytes merged into the target word.
    always_comb begin
        beat_word_c = ret_data_i;
        if (op_q && (cnt_q == off_c)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_q[b]) begin
                    beat_word_c[8*b +: 8] = wdata_q[8*b +: 8];
                end
            end
        end
    end

    // Request capture, beat collection, error tracking and registered strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q       <= '0;
            op_q         <= 1'b0;
            wstrb_q      <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            line_q       <= '0;
            load_word_q  <= '0;
            rd_req_q     <= 1'b0;
            fill_en_q    <= 1'b0;
            load_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            if ((state_q == IDLE) && start_i) begin
                addr_q  <= miss_addr_i[ADDR_W-1:OFF_LSB];
                op_q    <= miss_op_i;
                wstrb_q <= miss_wstrb_i;
                wdata_q <= miss_wdata_i;
            end
            // Fresh line per miss so words never returned read as zero.
            if ((state_q == REQ) && rd_rdy_i) begin
                cnt_q  <= '0;
                ovf_q  <= 1'b0;
                line_q <= '0;
            end
            if (beat_c) begin
                line_q[cnt_q] <= beat_word_c;
                cnt_q         <= cnt_q + CNT_W'(1);
                if (!op_q && (cnt_q == off_c)) begin
                    load_word_q <= ret_data_i;
                end
                // A wrap past the last word means the burst is already too long.
                if ((cnt_q == CNT_W'(BEATS-1)) && !ret_last_i) begin
                    ovf_q <= 1'b1;
                end
                if (ret_last_i && ((cnt_q != CNT_W'(BEATS-1)) || ovf_q)) begin
                    proto_err_q <= 1'b1;
                end
            end
            rd_req_q     <= (state_d == REQ);
            fill_en_q    <= (state_d == FILL);
            load_valid_q <= (state_d == FILL) && !op_q;
            busy_q       <= (state_d != IDLE);
        end
    end

    assign rd_req_o     = rd_req_q;
    assign rd_type_o    = 3'b100;
    assign rd_addr_o    = {addr_q[ADDR_W-1:IDX_LSB], 4'b0000};
    assign fill_en_o    = fill_en_q;
    assign fill_idx_o   = addr_q[IDX_LSB +: INDEXLEN];
    assign fill_tag_o   = addr_q[ADDR_W-1 -: TAGLEN];
    assign fill_line_o  = line_q;
    assign fill_dirty_o = op_q;
    assign load_word_o  = load_word_q;
    assign load_valid_o = load_valid_q;
    assign busy_o       = busy_q;
    assign proto_err_o  = proto_err_q;

endmodule
